event_byte_deframer: RTL

EVENT_BYTE_DEFRAMER -- requirements
Module: event_byte_deframer

---
 rtl/event_pkg.sv | 44 ++++
 rtl/event_byte_deframer_if.sv | 21 ++
 rtl/byte_timeout_counter.sv | 36 +++
 rtl/event_byte_deframer.sv | 154 +++++++++++++++
 4 files changed

// File: rtl/event_pkg.sv
// Shared widths, payload layout and FSM state type for the event deframer.
// The CHECK state exists only when EVT_CHECKSUM_EN is defined.
package event_pkg;

    localparam int TS_W    = 34;
    localparam int COORD_W = 14;
    localparam int PL_W    = 64;

    localparam int TS_LSB  = 0;
    localparam int X_LSB   = 34;
    localparam int Y_LSB   = 48;
    localparam int POL_BIT = 62;
    localparam int RSV_BIT = 63;

`ifdef EVT_CHECKSUM_EN
    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD,
        CHECK
    } state_e;
`else
    typedef enum logic [1:0] {
        HUNT,
        PAYLOAD
    } state_e;
`endif

    typedef struct packed {
        logic [TS_W-1:0]    ts;
        logic [COORD_W-1:0] x;
        logic [COORD_W-1:0] y;
        logic               pol;
    } event_t;

    function automatic event_t decode(input logic [PL_W-1:0] w);
        event_t e;
        e.ts  = w[TS_LSB +: TS_W];
        e.x   = w[X_LSB +: COORD_W];
        e.y   = w[Y_LSB +: COORD_W];
        e.pol = w[POL_BIT];
        return e;
    endfunction

endpackage

// File: rtl/event_byte_deframer_if.sv
// Byte-stream valid/ready bundle feeding the event deframer.
// The source drives data/valid, the deframer drives ready.
interface event_byte_deframer_if;

    logic [7:0] byte_data;
    logic       byte_valid;
    logic       byte_ready;

    modport master (
        output byte_data,
        output byte_valid,
        input  byte_ready
    );

    modport slave (
        input  byte_data,
        input  byte_valid,
        output byte_ready
    );

endinterface

// File: rtl/byte_timeout_counter.sv
// Idle-cycle counter: flags the LIMIT-th consecutive idle cycle while active.
// A byte in the same cycle wins over expiry.
module byte_timeout_counter #(
    parameter int LIMIT = 1024
) (
    input  logic clk_i,
    input  logic rst_ni,
    input  logic active_i,
    input  logic clear_i,
    output logic expire_o
);

    localparam int CW = (LIMIT > 1) ? $clog2(LIMIT) : 1;

    logic [CW-1:0] cnt_q;
    logic [CW-1:0] cnt_d;

    assign expire_o = active_i && !clear_i &&
                      (cnt_q == CW'(LIMIT - 1));

    always_comb begin
        cnt_d = cnt_q + 1'b1;
        if (!active_i || clear_i || expire_o) begin
            cnt_d = '0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

endmodule

// File: rtl/event_byte_deframer.sv
// Deframes SYNC + 8 little-endian payload bytes into event fields.
// Define EVT_CHECKSUM_EN to require a trailing XOR checksum byte.
module event_byte_deframer
    import event_pkg::*;
#(
    parameter logic [7:0] SYNC_BYTE      = 8'hA5,
    parameter int         TIMEOUT_CYCLES = 1024
) (
    input  logic               clk_i,
    input  logic               rst_ni,
    input  logic [7:0]         byte_i,
    input  logic               byte_valid_i,
    output logic               byte_ready_o,
    output logic [TS_W-1:0]    timestamp_o,
    output logic [COORD_W-1:0] x_coord_o,
    output logic [COORD_W-1:0] y_coord_o,
    output logic               polarity_o,
    output logic               is_valid_o,
    output logic               frame_err_o,
    output logic [15:0]        err_count_o
);

    state_e          state_q, state_d;
    logic [2:0]      idx_q, idx_d;
    logic [PL_W-1:0] asm_q, asm_d;
    event_t          ev_q, ev_d;
    logic            valid_q, valid_d;
    logic            err_q, err_d;
    logic [15:0]     errcnt_q, errcnt_d;
    logic            acc;
    logic            expire;
`ifdef EVT_CHECKSUM_EN
    logic [7:0]      csum_q, csum_d;
`endif

    // No backpressure: ready follows reset release directly.
    assign byte_ready_o = rst_ni;
    assign acc = byte_valid_i && byte_ready_o;

    byte_timeout_counter #(
        .LIMIT (TIMEOUT_CYCLES)
    ) u_timeout (
        .clk_i    (clk_i),
        .rst_ni   (rst_ni),
        .active_i (state_q != HUNT),
        .clear_i  (acc),
        .expire_o (expire)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        asm_d    = asm_q;
        ev_d     = ev_q;
        valid_d  = 1'b0;
        err_d    = 1'b0;
`ifdef EVT_CHECKSUM_EN
        csum_d   = csum_q;
`endif
        unique case (state_q)
            HUNT: begin
                if (acc && byte_i == SYNC_BYTE) begin
                    state_d = PAYLOAD;
                    idx_d   = '0;
                    asm_d   = '0;
`ifdef EVT_CHECKSUM_EN
                    csum_d  = '0;
`endif
                end
            end
            PAYLOAD: begin
                if (acc) begin
                    asm_d[{idx_q, 3'b000} +: 8] = byte_i;
                    idx_d = idx_q + 3'd1;
`ifdef EVT_CHECKSUM_EN
                    csum_d = csum_q ^ byte_i;
                    if (idx_q == 3'd7) begin
                        state_d = CHECK;
                    end
`else
                    if (idx_q == 3'd7) begin
                        state_d = HUNT;
                        if (asm_d[RSV_BIT]) begin
                            err_d = 1'b1;
                        end else begin
                            valid_d = 1'b1;
                            ev_d    = decode(asm_d);
                        end
                    end
`endif
                end else if (expire) begin
                    state_d = HUNT;
                    err_d   = 1'b1;
                end
            end
`ifdef EVT_CHECKSUM_EN
            CHECK: begin
                if (acc) begin
                    state_d = HUNT;
                    if (asm_q[RSV_BIT] || byte_i != csum_q) begin
                        err_d = 1'b1;
                    end else begin
                        valid_d = 1'b1;
                        ev_d    = decode(asm_q);
                    end
                end else if (expire) begin
                    state_d = HUNT;
                    err_d   = 1'b1;
                end
            end
`endif
            default: state_d = HUNT;
        endcase
        errcnt_d = errcnt_q;
        if (err_d && errcnt_q != 16'hFFFF) begin
            errcnt_d = errcnt_q + 16'd1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q  <= HUNT;
            idx_q    <= '0;
            asm_q    <= '0;
            ev_q     <= '0;
            valid_q  <= 1'b0;
            err_q    <= 1'b0;
            errcnt_q <= '0;
`ifdef EVT_CHECKSUM_EN
            csum_q   <= '0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            asm_q    <= asm_d;
            ev_q     <= ev_d;
            valid_q  <= valid_d;
            err_q    <= err_d;
            errcnt_q <= errcnt_d;
`ifdef EVT_CHECKSUM_EN
            csum_q   <= csum_d;
`endif
        end
    end

    assign timestamp_o = ev_q.ts;
    assign x_coord_o   = ev_q.x;
    assign y_coord_o   = ev_q.y;
    assign polarity_o  = ev_q.pol;
    assign is_valid_o  = valid_q;
    assign frame_err_o = err_q;
    assign err_count_o = errcnt_q;

endmodule
